// File: rtl/riscv_fetch_prefetch.sv
// riscv_fetch_prefetch
//
// Instruction-fetch front end. It acts as an OBI master towards the
// instruction memory, with at most one transaction outstanding. Fetched words
// go into a small prefetch FIFO together with their PCs, and decode takes them
// out over a valid/ready handshake. A branch empties the FIFO, moves the fetch
// address to the target, and drops any response that is still in flight.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   instr_req_o         OBI request (registered state)
//   instr_addr_o        OBI address, word aligned (registered)
//   instr_gnt_i         OBI grant, only looked at in REQ
//   instr_rvalid_i      OBI response valid, only looked at in WAIT
//   instr_rdata_i       OBI read data
//   branch_i            one-cycle redirect/flush pulse
//   branch_addr_i       redirect target, bits [1:0] ignored
//   instr_valid_o       FIFO head valid towards decode
//   instr_rdata_o       instruction at the FIFO head
//   instr_pc_o          PC of the FIFO head
//   instr_ready_i       decode takes the head this cycle
//   busy_o              FSM is not in IDLE

module riscv_fetch_prefetch #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        busy_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      fetch_addr_q;
    logic [31:0]      req_addr_q;
    logic             discard_q;
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]      fifo_instr_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [31:0] branch_target;
    logic        grant;
    logic        response;
    logic        push;
    logic        pop;
    logic        branch_addr_unused;

    assign branch_target      = {branch_addr_i[31:2], 2'b00};
    assign branch_addr_unused = ^branch_addr_i[1:0];

    assign grant    = (state_q == S_REQ) && instr_gnt_i;
    assign response = (state_q == S_WAIT) && instr_rvalid_i;

    // A flush wins over a same-cycle push or pop. It also kills a response
    // that lands in the same cycle as the branch.
    assign push = response && !discard_q && !branch_i;
    assign pop  = instr_valid_o && instr_ready_i && !branch_i;

    // Occupancy after this cycle. WAIT uses it to decide whether space is
    // left for the next request.
    always_comb begin
        count_d = count_q;
        if (branch_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. REQ only moves on a grant, so a branch never
    // withdraws a request that is still pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((count_q < DEPTH_C) && !branch_i) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (instr_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (instr_rvalid_i) begin
                    state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs, taken from the state and request-address registers only
    always_comb begin
        instr_req_o  = (state_q == S_REQ);
        instr_addr_o = req_addr_q;
        busy_o       = (state_q != S_IDLE);
    end

    // Fetch address, latched request address and the discard flag.
    // While discard is set, the pending request belongs to the old stream.
    // Its grant therefore must not advance the branch target held in
    // fetch_addr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_addr_q <= BOOT_ADDR;
            req_addr_q   <= BOOT_ADDR;
            discard_q    <= 1'b0;
        end else begin
            if (branch_i) begin
                fetch_addr_q <= branch_target;
            end else if (grant && !discard_q) begin
                fetch_addr_q <= fetch_addr_q + 32'd4;
            end

            if ((state_q != S_REQ) && (state_d == S_REQ)) begin
                req_addr_q <= branch_i ? branch_target : fetch_addr_q;
            end

            if (response) begin
                discard_q <= 1'b0;
            end else if (branch_i && (state_q != S_IDLE)) begin
                discard_q <= 1'b1;
            end
        end
    end

    // Prefetch FIFO storage. Pointers wrap naturally because the depth is a
    // power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (branch_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_pc_q[wr_ptr_q]    <= req_addr_q;
                    fifo_instr_q[wr_ptr_q] <= instr_rdata_i;
                    wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_rdata_o = fifo_instr_q[rd_ptr_q];
    assign instr_pc_o    = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_riscv_fetch_prefetch.sv
// tb_riscv_fetch_prefetch
//
// Self-checking bench for riscv_fetch_prefetch. The instruction memory is a
// simple OBI slave in which every word is a fixed function of its address.
// The decode-side model follows the instruction stream: each delivered
// instruction must carry the next sequential PC, and that PC restarts at the
// target on a branch and at BOOT_ADDR on reset. Directed scenarios add literal
// checks for the request address sequence.

module tb_riscv_fetch_prefetch;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0100;

    logic        clk;
    logic        reset_n;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;

    logic        gnt_block = 1'b0;
    logic [31:0] grant_log   [$];
    logic [31:0] deliver_log [$];
    logic [31:0] instr_log   [$];

    riscv_fetch_prefetch #(
        .FIFO_DEPTH (DEPTH),
        .BOOT_ADDR  (BOOT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_valid_o  (instr_valid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_pc_o     (instr_pc_o),
        .instr_ready_i  (instr_ready_i),
        .busy_o         (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting", name);
    endtask

    // Inputs change 1 time unit after the falling edge
    task automatic apply_stimulus(input logic br, input logic [31:0] br_addr, input logic rdy);
        @(negedge clk);
        #1;
        branch_i      = br;
        branch_addr_i = br_addr;
        instr_ready_i = rdy;
    endtask

    task automatic wait_grants(input int n, input string name);
        int k;
        k = 0;
        while (grant_log.size() < n && k < 300) begin
            @(negedge clk);
            #4;
            k++;
        end
        if (grant_log.size() < n) report_timeout(name);
    endtask

    task automatic wait_deliveries(input int n, input string name);
        int k;
        k = 0;
        while (deliver_log.size() < n && k < 300) begin
            @(negedge clk);
            #4;
            k++;
        end
        if (deliver_log.size() < n) report_timeout(name);
    endtask

    task automatic wait_req_state(input logic want_req, input logic want_busy, input string name);
        int k;
        k = 0;
        @(negedge clk);
        #4;
        while (!(instr_req_o == want_req && busy_o == want_busy) && k < 300) begin
            @(negedge clk);
            #4;
            k++;
        end
        if (!(instr_req_o == want_req && busy_o == want_busy)) report_timeout(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_req"},   {31'd0, instr_req_o},   32'd0);
        check_output({tag, "_addr"},  instr_addr_o,           BOOT);
        check_output({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
        check_output({tag, "_rdata"}, instr_rdata_o,          32'd0);
        check_output({tag, "_pc"},    instr_pc_o,             32'd0);
        check_output({tag, "_busy"},  {31'd0, busy_o},        32'd0);
    endtask

    // OBI slave: grant one falling edge after a request is seen, then return
    // the data two cycles later. Held in reset together with the DUT.
    initial begin : memory_model
        logic        pend;
        logic [31:0] pend_addr;
        logic [31:0] gnt_addr;
        pend           = 1'b0;
        pend_addr      = '0;
        gnt_addr       = '0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        forever begin
            @(negedge clk);
            instr_rvalid_i = 1'b0;
            if (!reset_n) begin
                instr_gnt_i = 1'b0;
                pend        = 1'b0;
            end else if (instr_gnt_i) begin
                instr_gnt_i = 1'b0;
                pend        = 1'b1;
                pend_addr   = gnt_addr;
            end else if (pend) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_word(pend_addr);
                pend           = 1'b0;
            end else if (instr_req_o && !gnt_block) begin
                instr_gnt_i = 1'b1;
                gnt_addr    = instr_addr_o;
            end
        end
    end

    // Per-cycle checker. Samples shortly before each rising edge.
    initial begin : compare
        logic [31:0] exp_pc;
        logic        prev_branch;
        logic        prev_hold;
        logic [31:0] prev_addr;
        exp_pc      = BOOT;
        prev_branch = 1'b0;
        prev_hold   = 1'b0;
        prev_addr   = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!reset_n) begin
                exp_pc      = BOOT;
                prev_branch = 1'b0;
                prev_hold   = 1'b0;
            end else begin
                if (prev_branch) check_output("flush_valid", {31'd0, instr_valid_o}, 32'd0);
                if (prev_hold) begin
                    check_output("obi_req_hold",  {31'd0, instr_req_o}, 32'd1);
                    check_output("obi_addr_hold", instr_addr_o, prev_addr);
                end
                check_output("addr_align", {30'd0, instr_addr_o[1:0]}, 32'd0);
                if (instr_req_o && instr_gnt_i) grant_log.push_back(instr_addr_o);
                if (branch_i) begin
                    exp_pc = {branch_addr_i[31:2], 2'b00};
                end else if (instr_valid_o && instr_ready_i) begin
                    check_output("deliver_pc",    instr_pc_o,    exp_pc);
                    check_output("deliver_instr", instr_rdata_o, mem_word(exp_pc));
                    deliver_log.push_back(instr_pc_o);
                    instr_log.push_back(instr_rdata_o);
                    exp_pc = exp_pc + 32'd4;
                end
                prev_branch = branch_i;
                prev_hold   = instr_req_o && !instr_gnt_i;
                prev_addr   = instr_addr_o;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int gi;
        int di;
        logic [31:0] old_addr;

        reset_n       = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        instr_ready_i = 1'b1;

        // Reset values, then boot fetch
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("boot_req_cycle1",  {31'd0, instr_req_o}, 32'd1);
        check_output("boot_addr_cycle1", instr_addr_o,         32'h0000_0100);
        wait_deliveries(2, "boot_deliver");
        if (deliver_log.size() >= 2) begin
            check_output("boot_pc0",    deliver_log[0], 32'h0000_0100);
            check_output("boot_instr0", instr_log[0],   32'h0050_0093);
            check_output("boot_pc1",    deliver_log[1], 32'h0000_0104);
        end

        // Backpressure: restart at 0 with decode stalled
        apply_stimulus(1'b1, 32'h0000_0000, 1'b0);
        apply_stimulus(1'b0, 32'h0000_0000, 1'b0);
        repeat (20) @(negedge clk);
        #4;
        check_output("bp_req_idle",  {31'd0, instr_req_o},   32'd0);
        check_output("bp_busy_idle", {31'd0, busy_o},        32'd0);
        check_output("bp_valid",     {31'd0, instr_valid_o}, 32'd1);
        check_output("bp_head_pc",   instr_pc_o,             32'h0000_0000);
        di = deliver_log.size();
        @(negedge clk);
        #1;
        gnt_block     = 1'b1;
        instr_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        #4;
        check_output("bp_drain_count", 32'(deliver_log.size() - di), DEPTH);
        if (deliver_log.size() >= di + 2) begin
            check_output("bp_drain_pc0", deliver_log[di],     32'h0000_0000);
            check_output("bp_drain_pc1", deliver_log[di + 1], 32'h0000_0004);
        end

        // Branch while 0x8 is outstanding
        gi = grant_log.size();
        @(negedge clk);
        #1;
        gnt_block = 1'b0;
        wait_grants(gi + 1, "wait_grant_0x8");
        if (grant_log.size() > gi) check_output("wait_grant_0x8_addr", grant_log[gi], 32'h0000_0008);
        apply_stimulus(1'b1, 32'h0000_0203, 1'b1);
        apply_stimulus(1'b0, 32'h0000_0000, 1'b1);
        gi = grant_log.size();
        di = deliver_log.size();
        wait_grants(gi + 1, "wait_branch_grant");
        if (grant_log.size() > gi) check_output("wait_branch_req", grant_log[gi], 32'h0000_0200);
        wait_deliveries(di + 1, "wait_branch_deliver");
        if (deliver_log.size() > di) check_output("wait_branch_pc", deliver_log[di], 32'h0000_0200);

        // Branch during REQ while the grant is held off
        @(negedge clk);
        #1;
        gnt_block = 1'b1;
        wait_req_state(1'b1, 1'b1, "req_branch_setup");
        old_addr = instr_addr_o;
        gi = grant_log.size();
        apply_stimulus(1'b1, 32'h0000_0300, 1'b1);
        apply_stimulus(1'b0, 32'h0000_0000, 1'b1);
        di = deliver_log.size();
        for (int c = 0; c < 3; c++) begin
            #2;
            check_output("req_branch_addr_stable", instr_addr_o, old_addr);
            @(negedge clk);
            #1;
        end
        gnt_block = 1'b0;
        wait_grants(gi + 2, "req_branch_grants");
        if (grant_log.size() >= gi + 2) begin
            check_output("req_branch_old_req",    grant_log[gi],     old_addr);
            check_output("req_branch_target_req", grant_log[gi + 1], 32'h0000_0300);
        end
        wait_deliveries(di + 1, "req_branch_deliver");
        if (deliver_log.size() > di) check_output("req_branch_pc", deliver_log[di], 32'h0000_0300);

        // Address wrap-around, branching from a quiet IDLE
        apply_stimulus(1'b0, 32'h0000_0000, 1'b0);
        wait_req_state(1'b0, 1'b0, "wrap_setup");
        gi = grant_log.size();
        di = deliver_log.size();
        apply_stimulus(1'b1, 32'hFFFF_FFFD, 1'b1);
        apply_stimulus(1'b0, 32'h0000_0000, 1'b1);
        wait_grants(gi + 2, "wrap_grants");
        if (grant_log.size() >= gi + 2) begin
            check_output("wrap_req0", grant_log[gi],     32'hFFFF_FFFC);
            check_output("wrap_req1", grant_log[gi + 1], 32'h0000_0000);
        end
        wait_deliveries(di + 2, "wrap_deliver");
        if (deliver_log.size() >= di + 2) begin
            check_output("wrap_pc0", deliver_log[di],     32'hFFFF_FFFC);
            check_output("wrap_pc1", deliver_log[di + 1], 32'h0000_0000);
        end

        // Asynchronous reset between grant and response
        gi = grant_log.size();
        wait_grants(gi + 1, "areset_grant");
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("areset");
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        gi = grant_log.size();
        di = deliver_log.size();
        wait_grants(gi + 1, "areset_restart");
        if (grant_log.size() > gi) check_output("areset_restart_req", grant_log[gi], 32'h0000_0100);
        wait_deliveries(di + 1, "areset_deliver");
        if (deliver_log.size() > di) begin
            check_output("areset_pc",    deliver_log[di], 32'h0000_0100);
            check_output("areset_instr", instr_log[di],   32'h0050_0093);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
